mem_lsu_stage: RTL and testbench
================================

// Module: mem_lsu_stage
// PURPOSE
//  Parametrised MEM stage with a real load/store unit. Issues data-bus requests with a
//  req/gnt/rvalid handshake and stalls the pipeline while a transaction is outstanding.
//  Builds byte strobes and lane-shifted store data; extracts and extends load data for XLEN 32/64.
//  Sits between EX/MEM and MEM/WB registers; drives the write-back, forwarding and trap flags.
// PARAMETERS
//  XLEN           32   datapath width, 32 or 64; 64 enables size=D (ld/sd, lwu)
//  RF_ADDR_WIDTH  5    register-file address width
//  BUS_TIMEOUT    64   cycles without gnt/rvalid before a bus-error trap; must be >=2
// PORTS
//  clk                 in   1          clock
//  rst_n               in   1          async active-low reset
//  mem_valid           in   1          instruction in MEM is valid
//  mem_pc_i/mem_inst_i in   XLEN       passed to mem_pc_o/mem_inst_o unchanged
//  mem_is_load_i       in   1          load instruction
//  mem_is_store_i      in   1          store instruction
//  mem_ls_addr_i       in   XLEN       effective address
//  mem_ls_size_i       in   2          0=B 1=H 2=W 3=D
//  mem_ls_unsigned_i   in   1          zero-extend load
//  mem_store_data_i    in   XLEN       rs2 value, LSB-aligned
//  mem_req_rf_i        in   1          writes rd
//  mem_rf_waddr_i      in   RF_ADDR_WIDTH  rd address
//  mem_alu_res_i       in   XLEN       non-load result
//  ex2mem_exp_flag     in   1          exception raised upstream
//  int_flag            in   1          pending interrupt
//  dbus_req_o          out  1          bus request, held until dbus_gnt_i
//  dbus_we_o           out  1          1=store
//  dbus_addr_o         out  XLEN       address, low log2(XLEN/8) bits zeroed
//  dbus_wdata_o        out  XLEN       store data shifted to byte lane
//  dbus_strb_o         out  XLEN/8     byte enables
//  dbus_gnt_i          in   1          request accepted
//  dbus_rvalid_i       in   1          response (read data or write ack)
//  dbus_rdata_i        in   XLEN       read data, full bus word
//  dbus_err_i          in   1          bus error, sampled with rvalid
//  mem_stall_o         out  1          freeze IF..EX/MEM registers
//  mem_req_rf_o        out  1          rd write enable to MEM/WB
//  mem_rf_waddr_o      out  RF_ADDR_WIDTH
//  mem_wb_data_o       out  XLEN       write-back data
//  mem_fw_rd_addr/mem_fw_data/mem_fw_valid  out  RF_ADDR_WIDTH/XLEN/1  forwarding
//  mem_exp_flag_o/mem_int_flag_o/mem_exp_int_flag_o  out 1  trap flags
//  mem_misalign_o      out  1          misaligned-access cause
// BEHAVIOUR
//  FSM IDLE->REQ->RESP->DONE->IDLE. Reset: IDLE, counter 0, dbus_req_o/stall/flags 0, data regs 0.
//  IDLE: mem_valid & (load|store) & ~ex2mem_exp_flag -> REQ in the same cycle. Stall asserts
//   combinationally. Other instructions pass through with zero latency; stall stays 0.
//  REQ: dbus_req_o=1, addr/we/wdata/strb stable; gnt -> RESP. Counter increments each cycle.
//  RESP: rvalid -> capture rdata/err into regs -> DONE. Counter hitting BUS_TIMEOUT in REQ or RESP
//   -> DONE with err=1.
//  DONE: stall=0, mem_req_rf_o = mem_req_rf_i & mem_valid & ~err. Then -> IDLE.
//   Best case: req at N, gnt at N, rvalid at N+1, DONE at N+2.
//  Strobe: B=1<<a, H=3<<a, W=0xF<<a, D=0xFF; a=addr low bits. wdata=store_data<<(8*a).
//  Load: lane select by a, sign-extend unless unsigned; size D with XLEN=32 is illegal (err).
//  mem_wb_data_o = load ? extracted data : mem_alu_res_i. fw_valid=mem_req_rf_o; fw_data=wb_data.
//  mem_exp_flag_o = ex2mem_exp_flag | err | misalign. mem_int_flag_o = int_flag & ~busy.
//   Interrupts never abort a granted transaction.
//  mem_exp_int_flag_o = OR of exp and int flags.
//  Upstream exception in IDLE: no bus access; flag passes through.
//  Async reset mid-transaction -> IDLE immediately; the bus slave shares rst_n.
// CONFIGURATION
//  MEM_MISALIGN_EXP_EN defined: address not size-aligned -> no request, IDLE->DONE.
//   mem_misalign_o=1 and mem_exp_flag_o=1 for that DONE cycle; no rd write.
//  Undefined: low address bits are truncated to size alignment and the access proceeds;
//   mem_misalign_o is tied 0.
// TESTING
//  XLEN=32 lb addr 0x1003, rdata 0x80FF_0000 -> strb 0x8, wb_data 0xFFFF_FF80, stall 2 cycles.
//  sh addr 0x2002, data 0x1234, gnt held low 3 cycles -> req held 3+1 cycles,
//   wdata 0x1234_0000, strb 0xC.
//  No gnt for 64 cycles -> DONE with mem_exp_flag_o=1, mem_req_rf_o=0.
//  lw addr 0x1001 with MEM_MISALIGN_EXP_EN -> no dbus_req_o, misalign=1.
//  lw addr 0x1001 without the macro -> addr 0x1000 is accessed.
//  XLEN=64 lwu addr 0x..4, rdata 0xF000_0000_0000_0000 -> wb_data 0x0000_0000_F000_0000.
//  rst_n low while in RESP -> next cycle IDLE, req 0, stall 0; a following add passes through.

Source files
------------

// File: rtl/mem_lsu_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu_stage_if
// Brief    : Data-bus req/gnt/rvalid interface between the LSU and its slave.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_lsu_stage_if #(
    parameter int XLEN = 32
);
    logic                dbus_req_o;
    logic                dbus_we_o;
    logic [XLEN-1:0]     dbus_addr_o;
    logic [XLEN-1:0]     dbus_wdata_o;
    logic [XLEN/8-1:0]   dbus_strb_o;
    logic                dbus_gnt_i;
    logic                dbus_rvalid_i;
    logic [XLEN-1:0]     dbus_rdata_i;
    logic                dbus_err_i;

    modport master (
        output dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, dbus_strb_o,
        input  dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i, dbus_err_i
    );

    modport slave (
        input  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, dbus_strb_o,
        output dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i, dbus_err_i
    );
endinterface
`default_nettype wire

// File: rtl/mem_lsu_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu_stage
// Brief    : MEM pipeline stage with load/store unit (req/gnt/rvalid data bus),
//            byte-lane steering, load extension, stall and trap generation.
//            Optional MEM_MISALIGN_EXP_EN: trap on misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lsu_stage #(
    parameter int XLEN          = 32,
    parameter int RF_ADDR_WIDTH = 5,
    parameter int BUS_TIMEOUT   = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_valid,
    input  logic [XLEN-1:0]          mem_pc_i,
    input  logic [XLEN-1:0]          mem_inst_i,
    output logic [XLEN-1:0]          mem_pc_o,
    output logic [XLEN-1:0]          mem_inst_o,
    input  logic                     mem_is_load_i,
    input  logic                     mem_is_store_i,
    input  logic [XLEN-1:0]          mem_ls_addr_i,
    input  logic [1:0]               mem_ls_size_i,
    input  logic                     mem_ls_unsigned_i,
    input  logic [XLEN-1:0]          mem_store_data_i,
    input  logic                     mem_req_rf_i,
    input  logic [RF_ADDR_WIDTH-1:0] mem_rf_waddr_i,
    input  logic [XLEN-1:0]          mem_alu_res_i,
    input  logic                     ex2mem_exp_flag,
    input  logic                     int_flag,
    mem_lsu_stage_if.master          dbus,
    output logic                     mem_stall_o,
    output logic                     mem_req_rf_o,
    output logic [RF_ADDR_WIDTH-1:0] mem_rf_waddr_o,
    output logic [XLEN-1:0]          mem_wb_data_o,
    output logic [RF_ADDR_WIDTH-1:0] mem_fw_rd_addr,
    output logic [XLEN-1:0]          mem_fw_data,
    output logic                     mem_fw_valid,
    output logic                     mem_exp_flag_o,
    output logic                     mem_int_flag_o,
    output logic                     mem_exp_int_flag_o,
    output logic                     mem_misalign_o
);

    localparam int c_NB = XLEN / 8;
    localparam int c_AW = $clog2(c_NB);
    localparam int c_CW = $clog2(BUS_TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_TO_LAST = c_CW'(BUS_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state, w_next;
    logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
    logic              r_err, w_err_nxt;
    logic              r_misalign, w_mis_nxt;
    logic [XLEN-1:0]   r_rdata, w_rdata_nxt;

    logic [c_AW-1:0]   w_lo, w_szmask, w_lane;
    logic [c_NB-1:0]   w_bmask;
    logic [XLEN-1:0]   w_shifted, w_keep, w_load;
    logic              w_sign;
    logic              w_start, w_illegal, w_mis_trap;
    logic              w_req, w_stall, w_done;

    assign w_lo      = mem_ls_addr_i[c_AW-1:0];
    assign w_start   = mem_valid & (mem_is_load_i | mem_is_store_i) & ~ex2mem_exp_flag;
    assign w_illegal = (XLEN == 32) && (mem_ls_size_i == 2'd3);
    assign w_done    = (r_state == S_DONE);

    always_comb begin
        w_szmask = '0;
        w_bmask  = '0;
        case (mem_ls_size_i)
            2'd0: begin w_szmask = '0;          w_bmask = c_NB'(1);  end
            2'd1: begin w_szmask = c_AW'(1);    w_bmask = c_NB'(3);  end
            2'd2: begin w_szmask = c_AW'(3);    w_bmask = c_NB'(15); end
            default: begin w_szmask = c_AW'(7); w_bmask = '1;        end
        endcase
    end

    // Without the misalign trap the offset is rounded down to size alignment.
    assign w_lane = w_lo & ~w_szmask;

`ifdef MEM_MISALIGN_EXP_EN
    assign w_mis_trap     = |(w_lo & w_szmask);
    assign mem_misalign_o = w_done & r_misalign;
`else
    assign w_mis_trap     = 1'b0;
    assign mem_misalign_o = 1'b0;
`endif

    assign dbus.dbus_req_o   = w_req;
    assign dbus.dbus_we_o    = mem_is_store_i;
    assign dbus.dbus_addr_o  = {mem_ls_addr_i[XLEN-1:c_AW], {c_AW{1'b0}}};
    assign dbus.dbus_wdata_o = mem_store_data_i << {w_lane, 3'b000};
    assign dbus.dbus_strb_o  = w_bmask << w_lane;

    assign w_shifted = r_rdata >> {w_lane, 3'b000};

    always_comb begin
        w_keep = '1;
        w_sign = 1'b0;
        case (mem_ls_size_i)
            2'd0:    begin w_keep = XLEN'(8'hFF);         w_sign = w_shifted[7];  end
            2'd1:    begin w_keep = XLEN'(16'hFFFF);      w_sign = w_shifted[15]; end
            2'd2:    begin w_keep = XLEN'(32'hFFFF_FFFF); w_sign = w_shifted[31]; end
            default: begin w_keep = '1;                   w_sign = 1'b0;          end
        endcase
    end

    assign w_load = (w_shifted & w_keep) |
                    ((w_sign & ~mem_ls_unsigned_i) ? ~w_keep : '0);

    always_comb begin
        w_next      = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_mis_nxt   = r_misalign;
        w_rdata_nxt = r_rdata;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_err_nxt = 1'b0;
                w_mis_nxt = 1'b0;
                if (w_start) begin
                    w_stall = 1'b1;
                    if (w_illegal) begin
                        w_err_nxt = 1'b1;
                        w_next    = S_DONE;
                    end else if (w_mis_trap) begin
                        w_mis_nxt = 1'b1;
                        w_next    = S_DONE;
                    end else begin
                        w_req = 1'b1;
                        if (dbus.dbus_gnt_i) begin
                            w_next = S_RESP;
                        end else begin
                            w_next    = S_REQ;
                            w_cnt_nxt = c_CW'(1);
                        end
                    end
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                w_req   = 1'b1;
                if (dbus.dbus_gnt_i) begin
                    w_next    = S_RESP;
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_TO_LAST) begin
                    w_next    = S_DONE;
                    w_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CW'(1);
                end
            end
            S_RESP: begin
                w_stall = 1'b1;
                if (dbus.dbus_rvalid_i) begin
                    w_rdata_nxt = dbus.dbus_rdata_i;
                    w_err_nxt   = dbus.dbus_err_i;
                    w_next      = S_DONE;
                end else if (r_cnt == c_TO_LAST) begin
                    w_next    = S_DONE;
                    w_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CW'(1);
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_misalign <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_nxt;
            r_err      <= w_err_nxt;
            r_misalign <= w_mis_nxt;
            r_rdata    <= w_rdata_nxt;
        end
    end

    // A trapping instruction passing straight through must not write rd.
    always_comb begin
        mem_req_rf_o = 1'b0;
        case (r_state)
            S_IDLE:  mem_req_rf_o = mem_req_rf_i & mem_valid & ~w_start & ~ex2mem_exp_flag;
            S_DONE:  mem_req_rf_o = mem_req_rf_i & mem_valid & ~r_err & ~r_misalign;
            default: mem_req_rf_o = 1'b0;
        endcase
    end

    assign mem_stall_o        = w_stall;
    assign mem_pc_o           = mem_pc_i;
    assign mem_inst_o         = mem_inst_i;
    assign mem_rf_waddr_o     = mem_rf_waddr_i;
    assign mem_wb_data_o      = mem_is_load_i ? w_load : mem_alu_res_i;
    assign mem_fw_rd_addr     = mem_rf_waddr_i;
    assign mem_fw_data        = mem_wb_data_o;
    assign mem_fw_valid       = mem_req_rf_o;
    assign mem_exp_flag_o     = ex2mem_exp_flag | (w_done & (r_err | r_misalign));
    assign mem_int_flag_o     = int_flag & ~w_stall;
    assign mem_exp_int_flag_o = mem_exp_flag_o | mem_int_flag_o;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_lsu_stage
// Brief    : Directed vector bench for mem_lsu_stage (XLEN 32 and 64 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_lsu_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // shared control inputs
    logic       valid, v64, is_ld, is_st, uns, req_rf, exp_in, intf;
    logic [1:0] size;
    logic [4:0] waddr;
    // 32-bit instance
    logic [31:0] pc, inst, addr, sdata, alu;
    logic [31:0] pc_o, inst_o, wb, fw_data;
    logic [4:0]  waddr_o, fw_addr;
    logic        stall, req_rf_o, fw_valid, exp_o, int_o, expint_o, mis_o;
    // 64-bit instance
    logic [63:0] pc64, addr64, sdata64, alu64;
    logic [63:0] pc64_o, inst64_o, wb64, fw_data64;
    logic [4:0]  waddr64_o, fw_addr64;
    logic        stall64, req_rf64, fw_valid64, exp64, int64, expint64, mis64;

    mem_lsu_stage_if #(.XLEN(32)) bus32 ();
    mem_lsu_stage_if #(.XLEN(64)) bus64 ();

    mem_lsu_stage #(.XLEN(32), .RF_ADDR_WIDTH(5), .BUS_TIMEOUT(64)) u32 (
        .clk(clk), .rst_n(rst_n), .mem_valid(valid),
        .mem_pc_i(pc), .mem_inst_i(inst), .mem_pc_o(pc_o), .mem_inst_o(inst_o),
        .mem_is_load_i(is_ld), .mem_is_store_i(is_st), .mem_ls_addr_i(addr),
        .mem_ls_size_i(size), .mem_ls_unsigned_i(uns), .mem_store_data_i(sdata),
        .mem_req_rf_i(req_rf), .mem_rf_waddr_i(waddr), .mem_alu_res_i(alu),
        .ex2mem_exp_flag(exp_in), .int_flag(intf), .dbus(bus32),
        .mem_stall_o(stall), .mem_req_rf_o(req_rf_o), .mem_rf_waddr_o(waddr_o),
        .mem_wb_data_o(wb), .mem_fw_rd_addr(fw_addr), .mem_fw_data(fw_data),
        .mem_fw_valid(fw_valid), .mem_exp_flag_o(exp_o), .mem_int_flag_o(int_o),
        .mem_exp_int_flag_o(expint_o), .mem_misalign_o(mis_o)
    );

    mem_lsu_stage #(.XLEN(64), .RF_ADDR_WIDTH(5), .BUS_TIMEOUT(64)) u64 (
        .clk(clk), .rst_n(rst_n), .mem_valid(v64),
        .mem_pc_i(pc64), .mem_inst_i(64'd0), .mem_pc_o(pc64_o), .mem_inst_o(inst64_o),
        .mem_is_load_i(is_ld), .mem_is_store_i(is_st), .mem_ls_addr_i(addr64),
        .mem_ls_size_i(size), .mem_ls_unsigned_i(uns), .mem_store_data_i(sdata64),
        .mem_req_rf_i(req_rf), .mem_rf_waddr_i(waddr), .mem_alu_res_i(alu64),
        .ex2mem_exp_flag(exp_in), .int_flag(intf), .dbus(bus64),
        .mem_stall_o(stall64), .mem_req_rf_o(req_rf64), .mem_rf_waddr_o(waddr64_o),
        .mem_wb_data_o(wb64), .mem_fw_rd_addr(fw_addr64), .mem_fw_data(fw_data64),
        .mem_fw_valid(fw_valid64), .mem_exp_flag_o(exp64), .mem_int_flag_o(int64),
        .mem_exp_int_flag_o(expint64), .mem_misalign_o(mis64)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic        un;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rd;
        logic [31:0] al;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [31:0] e_wb;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic ld, input logic st, input logic un, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] al,
                       input logic rf);
        valid = 1'b1; is_ld = ld; is_st = st; uns = un; size = sz;
        addr = a; sdata = sd; alu = al; req_rf = rf;
    endtask

    task automatic idle();
        valid = 1'b0; v64 = 1'b0; is_ld = 1'b0; is_st = 1'b0; req_rf = 1'b0; exp_in = 1'b0;
    endtask

    task automatic run64(input logic [1:0] sz, input logic un, input logic [63:0] a,
                         input logic [63:0] rd, input logic [7:0] e_strb, input logic [63:0] e_wb);
        logic [63:0] e_addr;
        e_addr = {a[63:3], 3'b000};
        v64 = 1'b1; is_ld = 1'b1; is_st = 1'b0; uns = un; size = sz; addr64 = a; req_rf = 1'b1;
        bus64.dbus_gnt_i = 1'b1;
        @(negedge clk);
        chk("x64 req", bus64.dbus_req_o, 1);
        chk("x64 strb", bus64.dbus_strb_o, e_strb);
        chk("x64 addr", bus64.dbus_addr_o, e_addr);
        @(posedge clk); #1;
        bus64.dbus_gnt_i = 1'b0; bus64.dbus_rvalid_i = 1'b1; bus64.dbus_rdata_i = rd;
        @(posedge clk); #1;
        bus64.dbus_rvalid_i = 1'b0;
        @(negedge clk);
        chk("x64 wb", wb64, e_wb);
        chk("x64 stall", stall64, 0);
        chk("x64 rf_we", req_rf64, 1);
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            ld   st   un   sz    addr          sdata         rdata         alu           strb  wdata         wb
        tbl[0] = '{1'b0,1'b0,1'b0,2'd0,32'h0000_0000,32'h0000_0000,32'h0000_0000,32'h0000_1111,4'h0,32'h0000_0000,32'h0000_1111};
        tbl[1] = '{1'b1,1'b0,1'b0,2'd0,32'h0000_1003,32'h0000_0000,32'h80FF_0000,32'h0000_0000,4'h8,32'h0000_0000,32'hFFFF_FF80};
        tbl[2] = '{1'b1,1'b0,1'b1,2'd0,32'h0000_1002,32'h0000_0000,32'h80FF_0000,32'h0000_0000,4'h4,32'h0000_0000,32'h0000_00FF};
        tbl[3] = '{1'b1,1'b0,1'b0,2'd1,32'h0000_1002,32'h0000_0000,32'h80FF_0000,32'h0000_0000,4'hC,32'h0000_0000,32'hFFFF_80FF};
        tbl[4] = '{1'b1,1'b0,1'b1,2'd1,32'h0000_1000,32'h0000_0000,32'h1234_8001,32'h0000_0000,4'h3,32'h0000_0000,32'h0000_8001};
        tbl[5] = '{1'b1,1'b0,1'b0,2'd2,32'h0000_1004,32'h0000_0000,32'hDEAD_BEEF,32'h0000_0000,4'hF,32'h0000_0000,32'hDEAD_BEEF};
        tbl[6] = '{1'b0,1'b1,1'b0,2'd0,32'h0000_2001,32'h0000_00AB,32'h0000_0000,32'h0000_0055,4'h2,32'h0000_AB00,32'h0000_0055};
        tbl[7] = '{1'b0,1'b1,1'b0,2'd1,32'h0000_2002,32'h0000_1234,32'h0000_0000,32'h0000_0066,4'hC,32'h1234_0000,32'h0000_0066};
        tbl[8] = '{1'b0,1'b1,1'b0,2'd2,32'h0000_2000,32'hCAFE_F00D,32'h0000_0000,32'h0000_0077,4'hF,32'hCAFE_F00D,32'h0000_0077};
        tbl[9] = '{1'b0,1'b0,1'b0,2'd0,32'h0000_0000,32'h0000_0000,32'h0000_0000,32'hFFFF_FFFF,4'h0,32'h0000_0000,32'hFFFF_FFFF};

        rst_n = 1'b0; idle(); uns = 1'b0; size = 2'd0; intf = 1'b0; waddr = 5'd7;
        pc = 32'h0; inst = 32'h13; addr = '0; sdata = '0; alu = '0;
        pc64 = '0; addr64 = '0; sdata64 = '0; alu64 = '0;
        bus32.dbus_gnt_i = 1'b0; bus32.dbus_rvalid_i = 1'b0; bus32.dbus_rdata_i = '0; bus32.dbus_err_i = 1'b0;
        bus64.dbus_gnt_i = 1'b0; bus64.dbus_rvalid_i = 1'b0; bus64.dbus_rdata_i = '0; bus64.dbus_err_i = 1'b0;

        @(negedge clk);
        chk("reset stall", stall, 0);
        chk("reset req", bus32.dbus_req_o, 0);
        chk("reset exp", exp_o, 0);
        chk("reset rf_we", req_rf_o, 0);
        chk("reset mis", mis_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            logic [31:0] e_addr;
            e_addr = {tbl[i].a[31:2], 2'b00};
            drv(tbl[i].ld, tbl[i].st, tbl[i].un, tbl[i].sz, tbl[i].a, tbl[i].sd, tbl[i].al,
                ~tbl[i].st);
            pc = 32'h100 + i;
            if (!tbl[i].ld && !tbl[i].st) begin
                @(negedge clk);
                chk("alu stall", stall, 0);
                chk("alu req", bus32.dbus_req_o, 0);
                chk("alu wb", wb, tbl[i].e_wb);
                chk("alu rf_we", req_rf_o, 1);
                chk("alu fw_valid", fw_valid, 1);
                chk("alu pc", pc_o, 32'h100 + i);
                @(posedge clk); #1;
                idle();
                continue;
            end
            bus32.dbus_gnt_i = 1'b1;
            @(negedge clk);
            chk("vec req", bus32.dbus_req_o, 1);
            chk("vec stall0", stall, 1);
            chk("vec we", bus32.dbus_we_o, tbl[i].st);
            chk("vec strb", bus32.dbus_strb_o, tbl[i].e_strb);
            chk("vec wdata", bus32.dbus_wdata_o, tbl[i].e_wdata);
            chk("vec addr", bus32.dbus_addr_o, e_addr);
            @(posedge clk); #1;
            bus32.dbus_gnt_i = 1'b0; bus32.dbus_rvalid_i = 1'b1; bus32.dbus_rdata_i = tbl[i].rd;
            @(negedge clk);
            chk("vec stall1", stall, 1);
            chk("vec req resp", bus32.dbus_req_o, 0);
            @(posedge clk); #1;
            bus32.dbus_rvalid_i = 1'b0;
            @(negedge clk);
            chk("vec stall done", stall, 0);
            chk("vec wb", wb, tbl[i].e_wb);
            chk("vec rf_we", req_rf_o, tbl[i].ld);
            chk("vec exp", exp_o, 0);
            @(posedge clk); #1;
            idle();
        end

        // sh with grant delayed: request held for 3+1 cycles
        drv(1'b0, 1'b1, 1'b0, 2'd1, 32'h2002, 32'h1234, 32'h99, 1'b0);
        for (int c = 0; c < 4; c++) begin
            bus32.dbus_gnt_i = (c == 3);
            @(negedge clk);
            chk("sh req held", bus32.dbus_req_o, 1);
            chk("sh stall held", stall, 1);
            chk("sh wdata", bus32.dbus_wdata_o, 32'h1234_0000);
            chk("sh strb", bus32.dbus_strb_o, 4'hC);
            @(posedge clk); #1;
        end
        bus32.dbus_gnt_i = 1'b0; bus32.dbus_rvalid_i = 1'b1;
        @(negedge clk);
        chk("sh req dropped", bus32.dbus_req_o, 0);
        @(posedge clk); #1;
        bus32.dbus_rvalid_i = 1'b0;
        @(negedge clk);
        chk("sh done stall", stall, 0);
        chk("sh done exp", exp_o, 0);
        @(posedge clk); #1;
        idle();

        // no grant: bus timeout after 64 stalled cycles
        begin
            int n_stall;
            n_stall = 0;
            drv(1'b1, 1'b0, 1'b0, 2'd2, 32'h3000, 32'h0, 32'h0, 1'b1);
            intf = 1'b1;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (!stall) break;
                if (c == 5) chk("int masked while busy", int_o, 0);
                n_stall++;
                @(posedge clk); #1;
            end
            chk("timeout stall cycles", n_stall, 64);
            chk("timeout exp", exp_o, 1);
            chk("timeout rf_we", req_rf_o, 0);
            chk("timeout int", int_o, 1);
            chk("timeout expint", expint_o, 1);
            @(posedge clk); #1;
            intf = 1'b0;
            idle();
        end

        // size D on XLEN=32 is illegal: no bus access, trap
        drv(1'b1, 1'b0, 1'b0, 2'd3, 32'h4000, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        chk("ldd32 req", bus32.dbus_req_o, 0);
        chk("ldd32 stall", stall, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ldd32 exp", exp_o, 1);
        chk("ldd32 rf_we", req_rf_o, 0);
        @(posedge clk); #1;
        idle();

        // misaligned lw
        drv(1'b1, 1'b0, 1'b0, 2'd2, 32'h1001, 32'h0, 32'h0, 1'b1);
`ifdef MEM_MISALIGN_EXP_EN
        @(negedge clk);
        chk("mis req", bus32.dbus_req_o, 0);
        chk("mis stall", stall, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mis flag", mis_o, 1);
        chk("mis exp", exp_o, 1);
        chk("mis rf_we", req_rf_o, 0);
`else
        bus32.dbus_gnt_i = 1'b1;
        @(negedge clk);
        chk("trunc req", bus32.dbus_req_o, 1);
        chk("trunc addr", bus32.dbus_addr_o, 32'h1000);
        chk("trunc strb", bus32.dbus_strb_o, 4'hF);
        @(posedge clk); #1;
        bus32.dbus_gnt_i = 1'b0; bus32.dbus_rvalid_i = 1'b1; bus32.dbus_rdata_i = 32'h1122_3344;
        @(posedge clk); #1;
        bus32.dbus_rvalid_i = 1'b0;
        @(negedge clk);
        chk("trunc wb", wb, 32'h1122_3344);
        chk("trunc mis", mis_o, 0);
`endif
        @(posedge clk); #1;
        idle();

        // upstream exception: no bus access, flag passes through
        drv(1'b1, 1'b0, 1'b0, 2'd2, 32'h1000, 32'h0, 32'h0, 1'b1);
        exp_in = 1'b1;
        @(negedge clk);
        chk("upexp req", bus32.dbus_req_o, 0);
        chk("upexp stall", stall, 0);
        chk("upexp exp", exp_o, 1);
        chk("upexp expint", expint_o, 1);
        @(posedge clk); #1;
        idle();

        // async reset while waiting for rvalid
        drv(1'b1, 1'b0, 1'b0, 2'd2, 32'h5000, 32'h0, 32'h0, 1'b1);
        bus32.dbus_gnt_i = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus32.dbus_gnt_i = 1'b0;
        @(negedge clk);
        chk("rst pre stall", stall, 1);
        #1;
        rst_n = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0000_ABCD, 1'b1);
        #1;
        chk("rst req", bus32.dbus_req_o, 0);
        chk("rst stall", stall, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst add wb", wb, 32'h0000_ABCD);
        chk("post-rst add rf_we", req_rf_o, 1);
        chk("post-rst stall", stall, 0);
        @(posedge clk); #1;
        idle();

        // XLEN=64 instance
        run64(2'd2, 1'b1, 64'h0000_0000_0000_1004, 64'hF000_0000_0000_0000,
              8'hF0, 64'h0000_0000_F000_0000);
        run64(2'd2, 1'b0, 64'h0000_0000_0000_1004, 64'hF000_0000_0000_0000,
              8'hF0, 64'hFFFF_FFFF_F000_0000);
        run64(2'd3, 1'b0, 64'h0000_0000_0000_2008, 64'h8000_0000_0000_0001,
              8'hFF, 64'h8000_0000_0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
